mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Memory-side initiator for the 8-bit datapath. It accepts load/store requests from the core over a valid/ready channel and sequences them onto the data memory's Addr_Bus / DataIn / RW / DataOut interface. The data memory is combinational and level-sensitive, so this block guarantees address setup before RW rises, a single-cycle RW write strobe, and address hold after it. Read data is registered and returned on a valid/ready response channel.

Parameters:
AW, 8, address width (Req_Addr, Addr_Bus)
DW, 8, data width (Req_WData, Rsp_RData, DataIn)
READ_LAT, 1, cycles Addr_Bus is held with RW=0 before DataOut is sampled; legal range 1..15, value 0 is an elaboration error
MEM_DEPTH, 256, number of implemented memory words; used only by the optional feature

Ports:
Clk  in  1  rising-edge clock
Reset  in  1  asynchronous, active-high reset
Req_Valid  in  1  core request valid
Req_Ready  out  1  block can accept a request
Req_Write  in  1  1 = store, 0 = load
Req_Addr  in  AW  word address
Req_WData  in  DW  store data
Rsp_Valid  out  1  response valid
Rsp_Ready  in  1  core accepts the response
Rsp_RData  out  DW  load data; 0 for stores
Rsp_Err  out  1  access fault (optional feature); otherwise 0
Addr_Bus  out  AW  memory address
DataIn  out  DW  memory write data
RW  out  1  1 = write, 0 = read
DataOut  in  17  memory read data; only bits [DW-1:0] are used, upper bits ignored

Behaviour:
- Reset (async): state IDLE, all outputs 0, including Req_Ready, RW, Addr_Bus and DataIn. The read-latency counter clears.
- States: IDLE, SETUP, WRITE, HOLD, READ, RESP. All outputs are registered, or decoded from registered state only.
- IDLE: Req_Ready=1, RW=0, Addr_Bus and DataIn hold their last values. Req_Valid&Req_Ready at cycle C captures Write/Addr/WData, then goes to SETUP.
- SETUP (C+1): Addr_Bus=addr, DataIn=wdata, RW=0. Goes to WRITE if store, else READ.
- WRITE (C+2): RW=1 for exactly one cycle, address and data stable. Goes to HOLD.
- HOLD (C+3): RW=0, address and data unchanged. Goes to RESP with Rsp_RData=0.
- READ: RW=0 for READ_LAT cycles (C+2 .. C+1+READ_LAT). On the last cycle, DataOut[DW-1:0] is registered into Rsp_RData. Goes to RESP.
- RESP: Rsp_Valid=1, with Rsp_RData and Rsp_Err stable until Rsp_Valid&Rsp_Ready. The handshake returns the block to IDLE on the next cycle.
- Latency from the accept cycle C to the first Rsp_Valid cycle: store C+4; load C+2+READ_LAT.
- Single outstanding request; Req_Ready=0 in every state except IDLE. Minimum request spacing = latency + 1.
- Req_Valid while not ready is ignored; no request state is captured.
- RW is never 1 outside WRITE, and never 1 in the same cycle Addr_Bus changes.
- Reset mid-operation: RW drops to 0 immediately and no response is issued. Memory contents at the aborted write address are undefined.

Optional Feature:
Macro MAU_BOUNDS_CHECK_EN.
- Defined: a request with Req_Addr >= MEM_DEPTH is accepted normally, then goes IDLE -> RESP at C+1 with Rsp_Err=1 and Rsp_RData=0. SETUP/WRITE/READ are skipped, RW stays 0, and Addr_Bus and DataIn are unchanged. In-range requests behave as above with Rsp_Err=0.
- Undefined: Rsp_Err is tied to 0, no comparison logic is generated, and every address is issued.

Test Plan:
- Reset asserted mid-READ -> same cycle: all outputs 0, Req_Ready=0. After release -> Req_Ready=1 on the first clock; no stray Rsp_Valid.
- Store 0x5A to 0x10, accepted at C -> Addr_Bus=0x10 and DataIn=0x5A from C+1; RW=1 only at C+2; Rsp_Valid at C+4 with Rsp_RData=0x00.
- READ_LAT=3, load 0x10, memory model returns 0x1005A -> RW=0 throughout; Rsp_Valid at C+5 with Rsp_RData=0x5A.
- Backpressure: Rsp_Ready low for 4 cycles during RESP with a second Req_Valid pending -> Rsp_Valid and Rsp_RData stable; Req_Ready=0; second request accepted only in the cycle after the handshake.
- Reset asserted during WRITE -> RW falls to 0 asynchronously within the same cycle; state returns to IDLE; no response.
- MAU_BOUNDS_CHECK_EN, MEM_DEPTH=128: load 0x80 -> Rsp_Valid at C+1 with Rsp_Err=1 and Rsp_RData=0, RW never 1. Load 0x7F -> normal timing with Rsp_Err=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences core load/store requests onto a combinational, level-sensitive data memory.
// Optional address bounds checking is enabled by defining MAU_BOUNDS_CHECK_EN.
module mem_access_unit #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int READ_LAT  = 1,
    parameter int MEM_DEPTH = 256
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Req_Valid,
    output logic          Req_Ready,
    input  logic          Req_Write,
    input  logic [AW-1:0] Req_Addr,
    input  logic [DW-1:0] Req_WData,
    output logic          Rsp_Valid,
    input  logic          Rsp_Ready,
    output logic [DW-1:0] Rsp_RData,
    output logic          Rsp_Err,
    output logic [AW-1:0] Addr_Bus,
    output logic [DW-1:0] DataIn,
    output logic          RW,
    input  logic [16:0]   DataOut
);
    if (READ_LAT < 1 || READ_LAT > 15) begin : g_bad_read_lat
        $error("mem_access_unit: READ_LAT must be in 1..15");
    end
    typedef enum logic [2:0] {IDLE, SETUP, WRITE, HOLD, READ, RESP} state_t;
    state_t        state_q, state_d;
    logic          rdy_q, rdy_d, wr_q, wr_d, err_q, err_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          accept, oob, unused_bits;
    assign accept = Req_Valid & rdy_q;
`ifdef MAU_BOUNDS_CHECK_EN
    assign oob = 32'(Req_Addr) >= MEM_DEPTH;
`else
    assign oob = 1'b0;
`endif
    assign unused_bits = ^{DataOut[16:DW], 32'(MEM_DEPTH)};
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (accept) begin
                wr_d    = Req_Write;
                err_d   = oob;
                rdata_d = '0;
                state_d = oob ? RESP : SETUP;
                // Faulting requests never touch the memory bus.
                addr_d  = oob ? addr_q : Req_Addr;
                wdata_d = oob ? wdata_q : Req_WData;
            end
            SETUP: begin
                state_d = wr_q ? WRITE : READ;
                cnt_d   = 4'(READ_LAT - 1);
            end
            WRITE: state_d = HOLD;
            HOLD:  state_d = RESP;
            READ: if (cnt_q == 4'd0) begin
                rdata_d = DataOut[DW-1:0];
                state_d = RESP;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            RESP:    state_d = Rsp_Ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
        rdy_d = state_d == IDLE;
    end
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end
    assign Req_Ready = rdy_q;
    assign Rsp_Valid = state_q == RESP;
    assign RW        = state_q == WRITE;
    assign Rsp_RData = rdata_q;
    assign Rsp_Err   = err_q;
    assign Addr_Bus  = addr_q;
    assign DataIn    = wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench for mem_access_unit with READ_LAT=3 and MEM_DEPTH=128.
module tb_mem_access_unit;
    logic        Clk = 1'b0, Reset = 1'b0;
    logic        Req_Valid = 1'b0, Req_Write = 1'b0, Rsp_Ready = 1'b0;
    logic [7:0]  Req_Addr = '0, Req_WData = '0;
    logic        Req_Ready, Rsp_Valid, Rsp_Err, RW;
    logic [7:0]  Rsp_RData, Addr_Bus, DataIn;
    logic [16:0] DataOut;
    logic [7:0]  mem [256];
    bit   [255:0] seen;
    int checks = 0, errors = 0;

    mem_access_unit #(.AW(8), .DW(8), .READ_LAT(3), .MEM_DEPTH(128)) dut (
        .Clk(Clk), .Reset(Reset), .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
        .Req_Write(Req_Write), .Req_Addr(Req_Addr), .Req_WData(Req_WData),
        .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_RData(Rsp_RData),
        .Rsp_Err(Rsp_Err), .Addr_Bus(Addr_Bus), .DataIn(DataIn), .RW(RW),
        .DataOut(DataOut)
    );

    always #5 Clk = ~Clk;

    // Memory model: unwritten words read back as their own address; upper bits are junk.
    always @(posedge Clk) if (RW) begin
        mem[Addr_Bus]  <= DataIn;
        seen[Addr_Bus] <= 1'b1;
    end
    assign DataOut = {9'h100, seen[Addr_Bus] ? mem[Addr_Bus] : Addr_Bus};

    task automatic step();
        @(negedge Clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, Req_Ready, 0);
        chk({tag, "_rw"}, RW, 0);
        chk({tag, "_addr"}, Addr_Bus, 0);
        chk({tag, "_din"}, DataIn, 0);
        chk({tag, "_rvalid"}, Rsp_Valid, 0);
        chk({tag, "_rdata"}, Rsp_RData, 0);
        chk({tag, "_err"}, Rsp_Err, 0);
    endtask

    task automatic request(input logic wr, input logic [7:0] a, input logic [7:0] d);
        Req_Valid = 1'b1;
        Req_Write = wr;
        Req_Addr  = a;
        Req_WData = d;
    endtask

    initial begin
        #1 Reset = 1'b1;
        step();
        chk_all_zero("reset");
        Reset = 1'b0;
        step();
        chk("ready_after_reset", Req_Ready, 1);
        chk("no_rsp_after_reset", Rsp_Valid, 0);

        // Store 0x5A to 0x10
        request(1'b1, 8'h10, 8'h5A);
        step();
        Req_Valid = 1'b0;
        chk("st_c1_addr", Addr_Bus, 8'h10);
        chk("st_c1_din", DataIn, 8'h5A);
        chk("st_c1_rw", RW, 0);
        chk("st_c1_ready", Req_Ready, 0);
        step();
        chk("st_c2_rw", RW, 1);
        chk("st_c2_addr", Addr_Bus, 8'h10);
        step();
        chk("st_c3_rw", RW, 0);
        chk("st_c3_rvalid", Rsp_Valid, 0);
        step();
        chk("st_c4_rvalid", Rsp_Valid, 1);
        chk("st_c4_rdata", Rsp_RData, 8'h00);
        chk("st_c4_err", Rsp_Err, 0);
        Rsp_Ready = 1'b1;
        step();
        Rsp_Ready = 1'b0;
        chk("st_done_rvalid", Rsp_Valid, 0);
        chk("st_done_ready", Req_Ready, 1);

        // Load 0x10 with READ_LAT=3
        request(1'b0, 8'h10, 8'h33);
        step();
        Req_Valid = 1'b0;
        chk("ld_c1_addr", Addr_Bus, 8'h10);
        chk("ld_c1_rw", RW, 0);
        for (int i = 2; i <= 4; i++) begin
            step();
            chk($sformatf("ld_c%0d_rw", i), RW, 0);
            chk($sformatf("ld_c%0d_rvalid", i), Rsp_Valid, 0);
        end
        step();
        chk("ld_c5_rvalid", Rsp_Valid, 1);
        chk("ld_c5_rdata", Rsp_RData, 8'h5A);

        // Backpressure with a second request pending
        request(1'b1, 8'h20, 8'hC3);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("bp%0d_rvalid", i), Rsp_Valid, 1);
            chk($sformatf("bp%0d_rdata", i), Rsp_RData, 8'h5A);
            chk($sformatf("bp%0d_ready", i), Req_Ready, 0);
            chk($sformatf("bp%0d_addr", i), Addr_Bus, 8'h10);
        end
        Rsp_Ready = 1'b1;
        step();
        Rsp_Ready = 1'b0;
        chk("bp_idle_rvalid", Rsp_Valid, 0);
        chk("bp_idle_ready", Req_Ready, 1);
        chk("bp_idle_addr", Addr_Bus, 8'h10);
        step();
        Req_Valid = 1'b0;
        chk("st2_c1_addr", Addr_Bus, 8'h20);
        chk("st2_c1_din", DataIn, 8'hC3);
        step();
        chk("st2_c2_rw", RW, 1);

        // Reset during WRITE
        #2 Reset = 1'b1;
        #1 chk_all_zero("rst_wr");
        step();
        Reset = 1'b0;
        step();
        chk("rst_wr_ready", Req_Ready, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("rst_wr_norsp%0d", i), Rsp_Valid, 0);
        end

        // Reset during READ
        request(1'b0, 8'h10, 8'h00);
        step();
        Req_Valid = 1'b0;
        step();
        chk("rd_mid_rw", RW, 0);
        #2 Reset = 1'b1;
        #1 chk_all_zero("rst_rd");
        step();
        Reset = 1'b0;
        step();
        chk("rst_rd_ready", Req_Ready, 1);
        step();
        step();
        chk("rst_rd_norsp", Rsp_Valid, 0);

`ifdef MAU_BOUNDS_CHECK_EN
        request(1'b0, 8'h80, 8'h00);
        step();
        Req_Valid = 1'b0;
        chk("oob_rvalid", Rsp_Valid, 1);
        chk("oob_err", Rsp_Err, 1);
        chk("oob_rdata", Rsp_RData, 0);
        chk("oob_rw", RW, 0);
        chk("oob_addr", Addr_Bus, 0);
        Rsp_Ready = 1'b1;
        step();
        Rsp_Ready = 1'b0;
        request(1'b0, 8'h7F, 8'h00);
        step();
        Req_Valid = 1'b0;
        chk("inb_c1_addr", Addr_Bus, 8'h7F);
        for (int i = 2; i <= 4; i++) begin
            step();
            chk($sformatf("inb_c%0d_rvalid", i), Rsp_Valid, 0);
        end
        step();
        chk("inb_rvalid", Rsp_Valid, 1);
        chk("inb_err", Rsp_Err, 0);
        chk("inb_rdata", Rsp_RData, 8'h7F);
        Rsp_Ready = 1'b1;
        step();
        Rsp_Ready = 1'b0;
`else
        request(1'b0, 8'h80, 8'h00);
        step();
        Req_Valid = 1'b0;
        chk("hi_c1_addr", Addr_Bus, 8'h80);
        chk("hi_c1_rvalid", Rsp_Valid, 0);
        repeat (4) step();
        chk("hi_rvalid", Rsp_Valid, 1);
        chk("hi_err", Rsp_Err, 0);
        chk("hi_rdata", Rsp_RData, 8'h80);
        Rsp_Ready = 1'b1;
        step();
        Rsp_Ready = 1'b0;
`endif
        chk("final_ready", Req_Ready, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
